video_axis_packer: RTL and testbench

Converts the raster video output of the mini16 SoC (DE, active-high HSYNC/VSYNC, 36-bit colour) into a frame-aligned AXI4-Stream video stream (tuser = start of frame, tlast = end of line) for the KV260 display pipeline. It sits directly downstream of the SoC video port in the video clock domain. Pixel input cannot be back-pressured, so the block buffers pixels in a FIFO. On overflow it drops the rest of the frame and resynchronises at the next frame.

---
 rtl/video_axis_packer.sv | 203 ++++++++++++++++++++
 tb/tb_video_axis_packer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_axis_packer.sv
// video_axis_packer
// Converts raster video (DE, active-high HSYNC/VSYNC, COLOR_WIDTH-bit pixels)
// into a frame-aligned AXI4-Stream: tuser marks the first pixel of a frame and
// tlast marks the last pixel of a line (taken from the DE falling edge). The
// pixel input cannot stall, so beats are buffered in a FWFT FIFO. On overflow
// the rest of the frame is dropped and the block waits for the next VSYNC.
// Optional build macro VIDEO_AXIS_STATS_EN adds the frame_count / line_count
// statistics outputs; without it those ports do not exist.
module video_axis_packer #(
  parameter int FIFO_DEPTH_LOG2 = 9,
  parameter int COLOR_WIDTH     = 36
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vga_de,
  input  logic                   vga_hs,
  input  logic                   vga_vs,
  input  logic [COLOR_WIDTH-1:0] vga_color,
  output logic [COLOR_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   overflow
`ifdef VIDEO_AXIS_STATS_EN
  ,
  output logic [15:0]            frame_count,
  output logic [11:0]            line_count
`endif
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int EW    = COLOR_WIDTH + 2;  // {tuser, tlast, data}
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_C = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    WAIT_SOF,
    ACTIVE,
    DROP
  } state_t;

  state_t                   state;
  logic                     vs_q;
  logic                     hs_q;
  logic [COLOR_WIDTH-1:0]   hold_data;
  logic                     hold_sof;
  logic                     hold_valid;
  logic                     sof_pending;

  logic                     vs_rise;
  logic                     pop;
  logic                     push_req;
  logic [EW-1:0]            push_entry;
  logic                     full;
  logic                     push_ok;
  logic                     drop;

  // FIFO storage: mem holds everything behind the registered output beat.
  logic [EW-1:0]            mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0] mem_count;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;
  logic                     load_out;
  logic                     mem_rd;
  logic                     mem_wr;
  logic                     bypass;

  // Horizontal sync is registered but does not take part in framing.
  logic                     unused_hs;
  assign unused_hs = hs_q;

  assign vs_rise    = vga_vs & ~vs_q;
  assign pop        = m_axis_tvalid & m_axis_tready;
  // Output register counts as one entry so total capacity is exactly DEPTH.
  assign fifo_count = mem_count + (FIFO_DEPTH_LOG2 + 1)'(m_axis_tvalid);
  assign full       = (fifo_count == DEPTH_C);

  // Push request from the hold stage; the held pixel ends the line when DE drops.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    push_req   = 1'b0;
    push_entry = '0;
    if (state == ACTIVE && hold_valid) begin
      push_req   = 1'b1;
      push_entry = {hold_sof, ~vga_de, hold_data};
    end
  end

  // A pop in the same cycle frees a slot, so a push on a full FIFO still succeeds.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // Output register refills from mem when it has data, else straight from the push.
  assign load_out = ~m_axis_tvalid | pop;
  assign mem_rd   = load_out & (mem_count != '0);
  assign bypass   = load_out & (mem_count == '0) & push_ok;
  assign mem_wr   = push_ok & ~bypass;

  // Framing FSM, sync edge detect and the one-pixel hold stage.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state       <= WAIT_SOF;
      vs_q        <= 1'b0;
      hs_q        <= 1'b0;
      hold_data   <= '0;
      hold_sof    <= 1'b0;
      hold_valid  <= 1'b0;
      sof_pending <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      vs_q <= vga_vs;
      hs_q <= vga_hs;
      unique case (state)
        WAIT_SOF, DROP: begin
          hold_valid <= 1'b0;
          if (vs_rise) begin
            state       <= ACTIVE;
            sof_pending <= 1'b1;
          end
        end
        ACTIVE: begin
          if (drop) begin
            overflow   <= 1'b1;
            hold_valid <= 1'b0;
            state      <= DROP;
          end else if (vga_de) begin
            // A pixel arriving on the VSYNC edge itself is the new frame's first.
            hold_data   <= vga_color;
            hold_sof    <= sof_pending | vs_rise;
            hold_valid  <= 1'b1;
            sof_pending <= 1'b0;
          end else begin
            hold_valid <= 1'b0;
            if (vs_rise) sof_pending <= 1'b1;
          end
        end
        default: state <= WAIT_SOF;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array is deliberately not reset; pointers and count define validity.
    if (mem_wr) mem[wr_ptr] <= push_entry;
  end

  // FIFO pointers, occupancy and the registered first-word-fall-through output.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      mem_count     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
      if (mem_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({mem_wr, mem_rd})
        2'b10:   mem_count <= mem_count + 1'b1;
        2'b01:   mem_count <= mem_count - 1'b1;
        default: mem_count <= mem_count;
      endcase
      if (load_out) begin
        if (mem_rd) begin
          {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= mem[rd_ptr];
          m_axis_tvalid <= 1'b1;
        end else if (bypass) begin
          {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= push_entry;
          m_axis_tvalid <= 1'b1;
        end else begin
          m_axis_tvalid <= 1'b0;
        end
      end
    end
  end

`ifdef VIDEO_AXIS_STATS_EN
  logic [11:0] lines_cur;

  // Count accepted frames; latch the line total of the frame that just ended.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
      line_count  <= '0;
      lines_cur   <= '0;
    end else if (pop) begin
      if (m_axis_tuser) begin
        frame_count <= frame_count + 1'b1;
        line_count  <= lines_cur;
        lines_cur   <= {11'd0, m_axis_tlast};
      end else if (m_axis_tlast) begin
        lines_cur <= lines_cur + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_video_axis_packer.sv
// Testbench for video_axis_packer: drives randomized raster video, builds the
// expected AXI4-Stream beat list from frame/line rules, and compares every
// accepted beat. Also checks stall stability and the optional statistics.
module tb_video_axis_packer;

  localparam int CW    = 36;
  localparam int LOG2  = 9;
  localparam int DEPTH = 1 << LOG2;

  typedef logic [CW+1:0] beat_t;  // {tuser, tlast, data}

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vga_de = 1'b0;
  logic          vga_hs = 1'b0;
  logic          vga_vs = 1'b0;
  logic [CW-1:0] vga_color = '0;
  logic [CW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          overflow;
`ifdef VIDEO_AXIS_STATS_EN
  logic [15:0]   frame_count;
  logic [11:0]   line_count;
`endif

  video_axis_packer #(.FIFO_DEPTH_LOG2(LOG2), .COLOR_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .vga_de(vga_de), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_color(vga_color),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .overflow(overflow)
`ifdef VIDEO_AXIS_STATS_EN
    , .frame_count(frame_count), .line_count(line_count)
`endif
  );

  always #5 clk = ~clk;

  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            ready_mode = 0;  // 0 ready, 1 toggle, 2 random, 3 stalled
  bit            model_active = 0;
  bit            model_sof = 0;
  beat_t         exp_q[$];
  beat_t         obs_q[$];
  logic [CW-1:0] line_px[$];
  bit            lat_arm = 0;
  int            tv_cyc = -1;
  bit            stalled = 0;
  beat_t         prev_beat;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted beat.
  always @(negedge clk)
    if (!reset && m_axis_tvalid && m_axis_tready)
      obs_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});

  // First tvalid after arming, for the latency check.
  always @(negedge clk)
    if (lat_arm && m_axis_tvalid) begin
      tv_cyc  = cyc;
      lat_arm = 0;
    end

  // A stalled beat must be held unchanged on the following cycle.
  always @(negedge clk) begin
    if (reset) stalled = 0;
    else begin
      if (stalled) begin
        vectors++;
        if (m_axis_tvalid !== 1'b1 ||
            {m_axis_tuser, m_axis_tlast, m_axis_tdata} !== prev_beat) begin
          miscompares++;
          $display("FAIL stall_stable: got tvalid=%0b beat=%h, required tvalid=1 beat=%h",
                   m_axis_tvalid, {m_axis_tuser, m_axis_tlast, m_axis_tdata}, prev_beat);
        end
      end
      stalled   = m_axis_tvalid && !m_axis_tready;
      prev_beat = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      2:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  endtask

  task automatic idle(input int n);
    vga_de = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    vga_de = 1'b0;
    vga_vs = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    obs_q.delete();
    exp_q.delete();
    model_active = 0;
    model_sof    = 0;
  endtask

  task automatic send_vsync();
    vga_de = 1'b0;
    vga_vs = 1'b1;
    vga_hs = 1'b1;
    repeat (3) tick();
    vga_vs = 1'b0;
    vga_hs = 1'b0;
    repeat (2) tick();
    model_active = 1;
    model_sof    = 1;
  endtask

  // One line of n random pixels followed by gap blank cycles.
  task automatic send_line(input int n, input int gap);
    logic [CW-1:0] c;
    line_px.delete();
    for (int i = 0; i < n; i++) begin
      c = CW'({$urandom(), $urandom()});
      line_px.push_back(c);
      vga_de    = 1'b1;
      vga_color = c;
      if (model_active) begin
        exp_q.push_back({model_sof, (i == n - 1), c});
        model_sof = 0;
      end
      tick();
    end
    vga_de = 1'b0;
    vga_hs = 1'b1;
    tick();
    vga_hs = 1'b0;
    repeat (gap) tick();
  endtask

  // Wait (bounded) for the expected beats, then compare beat by beat.
  task automatic check_stream(input string name, input int budget);
    int    t = 0;
    int    n;
    beat_t o, e;
    vga_de = 1'b0;
    while (obs_q.size() < exp_q.size() && t < budget) begin
      tick();
      t++;
    end
    repeat (8) tick();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s beat_count: got %0d, required %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      o = obs_q[i];
      e = exp_q[i];
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL %s beat %0d: got tuser=%0b tlast=%0b data=%h, required tuser=%0b tlast=%0b data=%h",
                 name, i, o[CW+1], o[CW], o[CW-1:0], e[CW+1], e[CW], e[CW-1:0]);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    vectors += 5;
    if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL %s tvalid: got %b, required 0", name, m_axis_tvalid); end
    if (m_axis_tuser  !== 1'b0) begin miscompares++; $display("FAIL %s tuser: got %b, required 0", name, m_axis_tuser); end
    if (m_axis_tlast  !== 1'b0) begin miscompares++; $display("FAIL %s tlast: got %b, required 0", name, m_axis_tlast); end
    if (m_axis_tdata  !== '0)   begin miscompares++; $display("FAIL %s tdata: got %h, required 0", name, m_axis_tdata); end
    if (overflow      !== 1'b0) begin miscompares++; $display("FAIL %s overflow: got %b, required 0", name, overflow); end
  endtask

  task automatic test_reset();
    do_reset();
    check_idle_outputs("reset");
`ifdef VIDEO_AXIS_STATS_EN
    vectors += 2;
    if (frame_count !== 16'd0) begin miscompares++; $display("FAIL reset frame_count: got %0d, required 0", frame_count); end
    if (line_count !== 12'd0)  begin miscompares++; $display("FAIL reset line_count: got %0d, required 0", line_count); end
`endif
  endtask

  task automatic test_no_sof();
    repeat (3) send_line(8, 2);
    check_stream("no_sof", 20);
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL no_sof overflow: got %b, required 0", overflow); end
  endtask

  task automatic test_frame();
    send_vsync();
    tv_cyc  = -1;
    lat_arm = 1;
    begin
      int de_cyc = cyc;
      repeat (4) send_line(8, 3);
      vectors++;
      if (tv_cyc != de_cyc + 2) begin
        miscompares++;
        $display("FAIL frame latency: first tvalid at cycle %0d, required %0d", tv_cyc, de_cyc + 2);
      end
    end
    check_stream("frame_4x8", 100);
  endtask

  task automatic test_single_pixel();
    send_vsync();
    repeat (6) send_line(1, $urandom_range(1, 4));
    check_stream("single_pixel", 50);
  endtask

  task automatic test_toggle();
    ready_mode = 1;
    send_vsync();
    repeat (4) send_line($urandom_range(1, 24), $urandom_range(1, 5));
    check_stream("ready_toggle", 400);
    ready_mode = 2;
    send_vsync();
    repeat (5) send_line($urandom_range(1, 24), $urandom_range(1, 5));
    check_stream("ready_random", 600);
    ready_mode = 0;
  endtask

  // VSYNC rising in the middle of a DE run: the pixel on that edge starts the frame.
  task automatic test_vs_mid_line();
    logic [CW-1:0] c;
    send_vsync();
    for (int i = 0; i < 10; i++) begin
      c = CW'({$urandom(), $urandom()});
      vga_de    = 1'b1;
      vga_vs    = (i == 4);
      vga_color = c;
      exp_q.push_back({(i == 0 || i == 4), (i == 9), c});
      tick();
    end
    vga_de = 1'b0;
    vga_vs = 1'b0;
    model_sof = 0;
    idle(3);
    check_stream("vs_mid_line", 50);
  endtask

  task automatic test_overflow();
    send_vsync();
    model_active = 0;
    ready_mode   = 3;
    idle(1);
    send_line(1024, 4);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == 0), 1'b0, line_px[i]});
    vectors += 3;
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL overflow flag: got %b, required 1", overflow); end
    if (m_axis_tvalid !== 1'b1) begin miscompares++; $display("FAIL overflow head_valid: got %b, required 1", m_axis_tvalid); end
    if ({m_axis_tuser, m_axis_tdata} !== {1'b1, line_px[0]}) begin
      miscompares++;
      $display("FAIL overflow head: got tuser=%b data=%h, required tuser=1 data=%h",
               m_axis_tuser, m_axis_tdata, line_px[0]);
    end
    send_line(16, 3);  // dropped: still waiting for a new frame
    ready_mode = 0;
    check_stream("overflow_drain", 2000);
    repeat (2) send_line(8, 3);
    check_stream("overflow_dropped", 30);
    send_vsync();
    repeat (2) send_line(8, 3);
    check_stream("overflow_recover", 60);
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL overflow sticky: got %b, required 1", overflow); end
  endtask

  task automatic test_reset_midframe();
    send_vsync();
    repeat (2) send_line(8, 2);
    check_stream("pre_reset", 40);
    vga_de = 1'b1;
    repeat (4) begin
      vga_color = CW'($urandom());
      tick();
    end
    reset = 1'b1;
    tick();
    check_idle_outputs("mid_reset");
    reset = 1'b0;
    vga_de = 1'b0;
    obs_q.delete();
    exp_q.delete();
    model_active = 0;
    model_sof    = 0;
    repeat (2) send_line(8, 2);
    check_stream("post_reset_no_sof", 30);
    send_vsync();
    repeat (3) send_line(8, 2);
    check_stream("post_reset_frame", 60);
  endtask

`ifdef VIDEO_AXIS_STATS_EN
  task automatic test_stats();
    do_reset();
    repeat (3) begin
      send_vsync();
      repeat (4) send_line(6, 2);
    end
    check_stream("stats_frames", 100);
    vectors += 2;
    if (frame_count !== 16'd3) begin miscompares++; $display("FAIL stats frame_count: got %0d, required 3", frame_count); end
    if (line_count !== 12'd4)  begin miscompares++; $display("FAIL stats line_count: got %0d, required 4", line_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_no_sof();
    test_frame();
    test_single_pixel();
    test_toggle();
    test_vs_mid_line();
    test_overflow();
    test_reset_midframe();
`ifdef VIDEO_AXIS_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
